// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU operation codes, opcodes, funct7 values and the
// registered operand bundle handed to execute.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_XOR  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SUB  = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_t         op;
    logic [4:0]      rd;
    logic            we;
  } ex_pkt_t;

  // Base operation selected by funct3; SUB/SRA come from funct7.
  function automatic alu_op_t f3_to_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, x0 reads as zero.
module regfile
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd
);
  logic [31:0][XLEN-1:0] r_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_mem <= '0;
    else if (i_we && i_wa != 5'd0)  r_mem[i_wa] <= i_wd;
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_mem[i_ra2];
endmodule

// File: rtl/decode_stage.sv
// RV32I decode/operand-fetch stage with busy scoreboard for RAW/WAW stalls.
// DECODE_WB_BYPASS_EN: forward same-cycle writeback data instead of stalling.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [3:0]  ex_alu_op,
  output logic [4:0]  ex_rd,
  output logic        ex_we,
  output logic        illegal
);
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  alu_op_t     w_op;
  logic        w_ill, w_use1, w_use2, w_lui, w_imm_sel, w_we;
  logic [31:0] w_imm, w_rf1, w_rf2, w_v1, w_v2;
  logic        w_m1, w_m2, w_h1, w_h2, w_hazard, w_acc, w_issue;
  logic [31:0] w_set, w_clr;

  logic        r_exv, r_ill;
  ex_pkt_t     r_ex;
  logic [31:0] r_busy;

  assign w_opc = instr[6:0];
  assign w_rd  = instr[11:7];
  assign w_f3  = instr[14:12];
  assign w_rs1 = instr[19:15];
  assign w_rs2 = instr[24:20];
  assign w_f7  = instr[31:25];

  always_comb begin
    w_op      = ALU_ADD;
    w_ill     = 1'b0;
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_lui     = 1'b0;
    w_imm_sel = 1'b0;
    w_imm     = '0;
    case (w_opc)
      OPC_OP: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_op   = f3_to_op(w_f3);
        if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'b000)      w_op = ALU_SUB;
          else if (w_f3 == 3'b101) w_op = ALU_SRA;
          else                     w_ill = 1'b1;
        end else if (w_f7 != F7_BASE) begin
          w_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_use1    = 1'b1;
        w_imm_sel = 1'b1;
        w_op      = f3_to_op(w_f3);
        w_imm     = {{20{instr[31]}}, instr[31:20]};
        // Shift-immediates reuse the upper imm bits as funct7.
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_imm = {27'b0, instr[24:20]};
          if (w_f3 == 3'b101 && w_f7 == F7_ALT) w_op = ALU_SRA;
          else if (w_f7 != F7_BASE)             w_ill = 1'b1;
        end
      end
      OPC_LUI: begin
        w_lui     = 1'b1;
        w_imm_sel = 1'b1;
        w_imm     = {instr[31:12], 12'b0};
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_use1 = 1'b0;
      w_use2 = 1'b0;
    end
  end

  assign w_we = !w_ill && (w_rd != 5'd0);

  assign w_m1 = wb_en && (wb_rd == w_rs1) && (w_rs1 != 5'd0);
  assign w_m2 = wb_en && (wb_rd == w_rs2) && (w_rs2 != 5'd0);

`ifdef DECODE_WB_BYPASS_EN
  assign w_h1 = w_use1 && r_busy[w_rs1] && !w_m1;
  assign w_h2 = w_use2 && r_busy[w_rs2] && !w_m2;
  assign w_v1 = w_m1 ? wb_data : w_rf1;
  assign w_v2 = w_m2 ? wb_data : w_rf2;
`else
  // Without forwarding a source being written this cycle must wait one edge.
  assign w_h1 = w_use1 && (r_busy[w_rs1] || w_m1);
  assign w_h2 = w_use2 && (r_busy[w_rs2] || w_m2);
  assign w_v1 = w_rf1;
  assign w_v2 = w_rf2;
`endif

  assign w_hazard    = w_h1 || w_h2 || (w_we && r_busy[w_rd]);
  assign instr_ready = (!r_exv || ex_ready) && !w_hazard;
  assign w_acc       = instr_valid && instr_ready;
  assign w_issue     = w_acc && !w_ill;

  assign w_set = (w_issue && w_we) ? (32'd1 << w_rd) : 32'd0;
  assign w_clr = wb_en ? (32'd1 << wb_rd) : 32'd0;

  regfile u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rf1),
    .o_rd2 (w_rf2),
    .i_we  (wb_en),
    .i_wa  (wb_rd),
    .i_wd  (wb_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exv  <= 1'b0;
      r_ill  <= 1'b0;
      r_ex   <= '0;
      r_busy <= '0;
    end else begin
      r_ill  <= w_acc && w_ill;
      // Set after clear so a same-cycle issue to the written register wins.
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
      if (w_issue) begin
        r_exv   <= 1'b1;
        r_ex.a  <= w_lui ? 32'd0 : w_v1;
        r_ex.b  <= w_imm_sel ? w_imm : w_v2;
        r_ex.op <= w_op;
        r_ex.rd <= w_rd;
        r_ex.we <= w_we;
      end else if (ex_ready) begin
        r_exv <= 1'b0;
      end
    end
  end

  assign ex_valid  = r_exv;
  assign ex_a      = r_ex.a;
  assign ex_b      = r_ex.b;
  assign ex_alu_op = r_ex.op;
  assign ex_rd     = r_ex.rd;
  assign ex_we     = r_ex.we;
  assign illegal   = r_ill;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage against an architectural model.
module tb_decode_stage;
  logic        clk = 1'b0, rst;
  logic        instr_valid, instr_ready, wb_en, ex_valid, ex_ready, ex_we, illegal;
  logic [31:0] instr, wb_data, ex_a, ex_b;
  logic [4:0]  wb_rd, ex_rd;
  logic [3:0]  ex_alu_op;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_we(ex_we), .illegal(illegal)
  );

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  // funct3 -> operation: ADD SLL SLT SLTU XOR SRL OR AND
  localparam bit [3:0] F3OP [8] = '{4'd0, 4'd4, 4'd7, 4'd8, 4'd1, 4'd5, 4'd2, 4'd3};

  typedef struct { bit ill; bit [31:0] a, b; bit [3:0] op; bit [4:0] rd; bit we; } exp_t;
  typedef struct { bit ill, u1, u2, lui, immb, we; bit [3:0] op; bit [4:0] rd, rs1, rs2; bit [31:0] imm; } dec_t;

  exp_t      q[$];
  int        n_chk = 0, n_pass = 0;
  bit [31:0] m_reg [32];
  bit        m_busy [32];
  bit        m_exv, m_ill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic dec_t m_dec(input bit [31:0] w);
    dec_t d;
    bit [2:0] f3 = w[14:12];
    bit [6:0] f7 = w[31:25];
    bit alt = (f7 == 7'h20);
    d = '{default: 0};
    d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
    d.op = F3OP[f3];
    case (w[6:0])
      7'b0110011: begin
        d.u1 = 1; d.u2 = 1;
        if (alt && f3 == 0) d.op = 4'd9;
        else if (alt && f3 == 5) d.op = 4'd6;
        d.ill = !(f7 == 0 || (alt && (f3 == 0 || f3 == 5)));
      end
      7'b0010011: begin
        d.u1 = 1; d.immb = 1;
        if (f3 == 1 || f3 == 5) begin
          d.imm = {27'b0, w[24:20]};
          d.ill = !(f7 == 0 || (f3 == 5 && alt));
          if (f3 == 5 && alt) d.op = 4'd6;
        end else d.imm = {{20{w[31]}}, w[31:20]};
      end
      7'b0110111: begin d.lui = 1; d.immb = 1; d.op = 4'd0; d.imm = {w[31:12], 12'b0}; end
      default: d.ill = 1;
    endcase
    if (d.ill) begin d.u1 = 0; d.u2 = 0; end
    d.we = !d.ill && d.rd != 0;
    return d;
  endfunction

  function automatic bit [31:0] m_src(input bit [4:0] r);
    if (r == 0) return 32'd0;
    if (BYP && wb_en && wb_rd == r) return wb_data;
    return m_reg[r];
  endfunction

  function automatic bit m_haz_src(input bit [4:0] r);
    bit wbm = wb_en && wb_rd == r && r != 0;
    return BYP ? (m_busy[r] && !wbm) : (m_busy[r] || wbm);
  endfunction

  // One cycle: drive at posedge+1, check combinational ready, advance model at the edge.
  task automatic step(input bit v, input bit [31:0] ins, input bit we, input bit [4:0] wr,
                      input bit [31:0] wd, input bit rdy, output bit acc);
    dec_t d; bit haz, er; exp_t e;
    instr_valid = v; instr = ins; wb_en = we; wb_rd = wr; wb_data = wd; ex_ready = rdy;
    #1;
    d   = m_dec(ins);
    haz = (d.u1 && m_haz_src(d.rs1)) || (d.u2 && m_haz_src(d.rs2)) || (d.we && m_busy[d.rd]);
    er  = (!m_exv || rdy) && !haz;
    chk("instr_ready", instr_ready, er);
    chk("ex_valid", ex_valid, m_exv);
    chk("illegal", illegal, m_ill);
    acc  = v && er;
    e.ill = d.ill; e.op = d.op; e.rd = d.rd; e.we = d.we;
    e.a  = d.lui ? 32'd0 : m_src(d.rs1);
    e.b  = d.immb ? d.imm : m_src(d.rs2);
    @(posedge clk);
    m_ill = acc && d.ill;
    if (acc) q.push_back(e);
    if (acc && !d.ill) m_exv = 1; else if (rdy) m_exv = 0;
    if (we) begin m_busy[wr] = 0; if (wr != 0) m_reg[wr] = wd; end
    if (acc && d.we) m_busy[d.rd] = 1;
    #1;
  endtask

  function automatic bit [31:0] rnd_instr();
    bit [31:0] w = $urandom;
    bit [6:0] bad [4] = '{7'b1100011, 7'b0000011, 7'b0100011, 7'b1101111};
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin
        w[6:0] = 7'b0110011;
        w[31:25] = ($urandom_range(0, 2) == 0) ? 7'b0100000 : 7'b0;
        if ($urandom_range(0, 11) == 0) w[31:25] = 7'($urandom);
      end
      4, 5, 6: begin
        w[6:0] = 7'b0010011;
        if (w[13:12] == 2'b01) begin
          w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0;
          if ($urandom_range(0, 7) == 0) w[31:25] = 7'($urandom);
        end
      end
      7: w[6:0] = 7'b0110111;
      8: w[6:0] = bad[$urandom_range(0, 3)];
      default: ;
    endcase
    w[11:10] = 2'b0; w[19:18] = 2'b0; w[24:23] = 2'b0;  // keep registers within x0..x7
    return w;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
    m_exv = 0; m_ill = 0;
    q.delete();
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (illegal) begin
        chk("illegal_queued", q.size() != 0, 1'b1);
        if (q.size() != 0) begin e = q.pop_front(); chk("illegal_order", e.ill, 1'b1); end
      end
      if (ex_valid) begin
        chk("out_queued", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q[0];
          chk("out_kind", e.ill, 1'b0);
          chk("ex_a", ex_a, e.a);
          chk("ex_b", ex_b, e.b);
          chk("ex_alu_op", ex_alu_op, e.op);
          chk("ex_rd", ex_rd, e.rd);
          chk("ex_we", ex_we, e.we);
          if (ex_ready) void'(q.pop_front());
        end
      end
    end
  end

  localparam bit [31:0] ADD3  = 32'h002081B3, ADDI4 = 32'hFFF00213, SRAI5 = 32'h40425293;
  localparam bit [31:0] LUI6  = 32'h12345337, SUB7  = 32'h401183B3, BEQ   = 32'h00000063;
  localparam bit [31:0] ADDI9 = 32'h00100493, ADDI10 = 32'h00148513;

  initial begin
    bit acc;
    int tries;
    rst = 1; instr_valid = 0; instr = 0; wb_en = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
    m_reset();
    #12;
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_ex_a", ex_a, 32'd0);
    chk("rst_ex_b", ex_b, 32'd0);
    chk("rst_ex_alu_op", ex_alu_op, 4'd0);
    chk("rst_ex_rd", ex_rd, 5'd0);
    chk("rst_ex_we", ex_we, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_instr_ready", instr_ready, 1'b1);
    @(posedge clk); #1 rst = 0;

    step(0, 0, 1, 1, 32'd5, 1, acc);
    step(0, 0, 1, 2, 32'd3, 1, acc);
    step(1, ADD3, 0, 0, 0, 1, acc);
    step(1, ADDI4, 0, 0, 0, 1, acc);
    step(1, SRAI5, 0, 0, 0, 1, acc);
    step(1, SRAI5, 0, 0, 0, 1, acc);
    step(1, SRAI5, 1, 4, 32'hFFFFFFFF, 1, acc);
    if (!acc) step(1, SRAI5, 0, 0, 0, 1, acc);
    step(1, LUI6, 0, 0, 0, 1, acc);
    step(1, SUB7, 0, 0, 0, 1, acc);
    step(1, SUB7, 0, 0, 0, 1, acc);
    step(1, SUB7, 1, 3, 32'h0000ABCD, 1, acc);
    if (!acc) step(1, SUB7, 0, 0, 0, 1, acc);
    repeat (3) step(1, LUI6, 0, 0, 0, 0, acc);
    step(1, LUI6, 0, 0, 0, 1, acc);
    step(1, BEQ, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 7, acc);

    // Park a stalled instruction on x9 (never written back) and reset mid-stall.
    tries = 0;
    do begin step(1, ADDI9, 0, 0, 0, 1, acc); tries++; end while (!acc && tries < 20);
    chk("addi9_issued", acc, 1'b1);
    step(1, ADDI10, 0, 0, 0, 1, acc);
    step(1, ADDI10, 0, 0, 0, 1, acc);
    #2 rst = 1;
    #1;
    chk("arst_ex_valid", ex_valid, 1'b0);
    chk("arst_ex_a", ex_a, 32'd0);
    chk("arst_ex_b", ex_b, 32'd0);
    chk("arst_ex_alu_op", ex_alu_op, 4'd0);
    chk("arst_ex_rd", ex_rd, 5'd0);
    chk("arst_ex_we", ex_we, 1'b0);
    chk("arst_illegal", illegal, 1'b0);
    chk("arst_busy_clear", instr_ready, 1'b1);
    m_reset();
    @(posedge clk); #1 rst = 0;

    step(1, ADD3, 0, 0, 0, 1, acc);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 7, acc);
    repeat (4) step(0, 0, 0, 0, 0, 1, acc);
    chk("drain", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
